// File: rtl/fp_to_int.sv
// fp_to_int: iterative 13-bit float (sign/exp4/frac8) to signed integer converter.
// Define FP_TO_INT_ROUND_EN for round-half-away-from-zero; otherwise truncates toward zero.
module fp_to_int #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [3:0]       in_exp,
    input  logic [7:0]       in_frac,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state_q, state_d;
    logic [14:0] mag_q, mag_d;
    logic [3:0] cnt_q, cnt_d;
    logic sign_q, sign_d, dir_q, dir_d;
    logic out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d, ext;
    logic [15:0] res;
`ifdef FP_TO_INT_ROUND_EN
    logic guard_q, guard_d, sticky_q, sticky_d;
`endif
    assign in_ready  = state_q == IDLE;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        dir_d       = dir_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef FP_TO_INT_ROUND_EN
        guard_d  = guard_q;
        sticky_d = sticky_q;
        res      = {1'b0, mag_q} + 16'(guard_q);
`else
        res = {1'b0, mag_q};
`endif
        ext = OUT_W'(res);
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d  = in_sign;
                mag_d   = {7'b0, in_frac};
                cnt_d   = in_exp[3] ? in_exp - 4'd8 : 4'd8 - in_exp;
                dir_d   = in_exp[3];
`ifdef FP_TO_INT_ROUND_EN
                guard_d  = 1'b0;
                sticky_d = 1'b0;
`endif
                state_d = SHIFT;
            end
            SHIFT: if (cnt_q != 4'd0) begin
                if (dir_q) mag_d = mag_q << 1;
                else begin
`ifdef FP_TO_INT_ROUND_EN
                    sticky_d = sticky_q | guard_q;
                    guard_d  = mag_q[0];
`endif
                    mag_d = mag_q >> 1;
                end
                cnt_d = cnt_q - 4'd1;
            end else begin
                // negating zero yields zero, so no negative-zero special case
                out_data_d  = sign_q ? -ext : ext;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef FP_TO_INT_ROUND_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef FP_TO_INT_ROUND_EN
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
`endif
        end
    end
endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: directed self-checking bench for fp_to_int with a real-arithmetic reference model.
module tb_fp_to_int;
`ifdef FP_TO_INT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    logic clk = 0, rst_n = 0, in_valid = 0, in_sign = 0, out_ready = 0;
    logic [3:0] in_exp = 0;
    logic [7:0] in_frac = 0;
    logic in_ready, out_valid;
    logic [15:0] out_data;
    logic [15:0] exp_data = 0;
    int total = 0, passed = 0;

    fp_to_int #(.OUT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input bit s, input int e, input int f);
        real v;
        int m;
        v = real'(f);
        for (int i = 8; i < e; i++) v = v * 2.0;
        for (int i = e; i < 8; i++) v = v / 2.0;
        m = RND ? int'($floor(v + 0.5)) : int'($floor(v));
        return s ? 16'(-m) : 16'(m);
    endfunction

    task automatic chk(input string n, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, act, act, req, req);
    endtask

    always @(negedge clk) if (rst_n && out_valid) chk("out_data", int'(out_data), int'(exp_data));

    task automatic op(input bit s, input int e, input int f, input int hold);
        int lat, b;
        @(posedge clk); #1;
        in_valid = 1; in_sign = s; in_exp = 4'(e); in_frac = 8'(f); out_ready = 0;
        b = 0;
        while (!in_ready && b < 20) begin @(posedge clk); #1; b++; end
        chk("accept_ready", int'(in_ready), 1);
        exp_data = model(s, e, f);
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, (e >= 8 ? e - 8 : 8 - e) + 1);
        for (int i = 0; i < hold; i++) begin
            chk("bp_in_ready", int'(in_ready), 0);
            in_valid = 1; in_sign = 0; in_exp = 4'd15; in_frac = 8'hFF;
            @(posedge clk); #1;
            chk("bp_out_valid", int'(out_valid), 1);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("release_valid", int'(out_valid), 0);
        chk("release_ready", int'(in_ready), 1);
        chk("data_kept", int'(out_data), int'(exp_data));
    endtask

    initial begin
        chk("pin_exp8", int'(model(0, 8, 'hC0)), 'h00C0);
        chk("pin_max", int'(model(0, 15, 'hFF)), 'h7F80);
        chk("pin_rshift", int'(model(1, 4, 'hB8)), RND ? 'hFFF4 : 'hFFF5);
        chk("pin_zero", int'(model(1, 5, 0)), 0);
        chk("pin_shiftout", int'(model(0, 0, 'h80)), RND ? 1 : 0);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        #13 rst_n = 1;
        @(posedge clk); #1;
        chk("rst_ready", int'(in_ready), 1);
        op(0, 8, 'hC0, 0);
        op(0, 15, 'hFF, 0);
        op(1, 4, 'hB8, 0);
        op(1, 5, 'h00, 0);
        op(0, 0, 'h80, 0);
        op(0, 9, 'h81, 5);
        op(1, 12, 'h90, 0);
        op(0, 7, 'h03, 0);
        op(1, 6, 'hFF, 0);
        op(1, 0, 'hFF, 0);
        // abort an exp=0 conversion mid-shift
        @(posedge clk); #1;
        in_valid = 1; in_sign = 0; in_exp = 4'd0; in_frac = 8'hFF;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_data", int'(out_data), 0);
        chk("abort_ready", int'(in_ready), 1);
        #3 rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) chk("abort_no_result", int'(out_valid), 0);
        end
        chk("abort_idle_ready", int'(in_ready), 1);
        op(0, 10, 'hA5, 2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
